// File: rtl/seg_display_arbiter_if.sv
// Display bus between the two requesters and the seven-segment scan arbiter.
// master = requester side, slave = arbiter side.
interface seg_display_arbiter_if;
  logic        req0;
  logic [15:0] dat0;
  logic        req1;
  logic [15:0] dat1;
  logic        gnt0;
  logic        gnt1;
  logic [3:0]  an;
  logic [3:0]  code;
  logic        frame_done;

  modport master (
    output req0, dat0, req1, dat1,
    input  gnt0, gnt1, an, code, frame_done
  );

  modport slave (
    input  req0, dat0, req1, dat1,
    output gnt0, gnt1, an, code, frame_done
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// 4-digit seven-segment scan controller with a frame-aligned two-requester arbiter.
// Ownership and displayed content only change at frame boundaries.
module seg_display_arbiter #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned HOLD_FRAMES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  seg_display_arbiter_if.slave bus
);

  localparam int unsigned DW = $clog2(REFRESH_DIV);
  localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_FRAMES - 1);
  localparam logic [15:0]   BLANK_ALL  = 16'hBBBB;

  typedef enum logic [1:0] {IDLE, SHOW0, SHOW1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] dwell;
  logic [1:0]    idx;
  logic [3:0]    an_q;
  logic [HW-1:0] hold;
  logic [15:0]   snap;
  logic [15:0]   snap_nxt;
  logic          gnt0_q;
  logic          gnt1_q;
  logic          terminal;
  logic          frame_end;
  logic [3:0]    code_sel;

  assign terminal  = (dwell == DWELL_LAST);
  assign frame_end = terminal && (idx == 2'd3);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req1)      state_nxt = SHOW1;
        else if (bus.req0) state_nxt = SHOW0;
      end
      SHOW0: begin
        if (bus.req1)       state_nxt = SHOW1;
        else if (!bus.req0) state_nxt = IDLE;
      end
      SHOW1: begin
        // req0 only matters once the hold has expired and req1 is gone
        if ((hold == '0) && !bus.req1)
          state_nxt = bus.req0 ? SHOW0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    snap_nxt = BLANK_ALL;
    case (state_nxt)
      SHOW0:   snap_nxt = bus.dat0;
      SHOW1:   snap_nxt = bus.dat1;
      default: snap_nxt = BLANK_ALL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      dwell  <= '0;
      idx    <= '0;
      an_q   <= 4'b1110;
      hold   <= '0;
      snap   <= BLANK_ALL;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
    end else begin
      if (terminal) begin
        dwell <= '0;
        idx   <= idx + 2'd1;
        an_q  <= {an_q[2:0], an_q[3]};
      end else begin
        dwell <= dwell + DW'(1);
      end

      if (frame_end) begin
        state  <= state_nxt;
        snap   <= snap_nxt;
        gnt0_q <= (state_nxt == SHOW0);
        gnt1_q <= (state_nxt == SHOW1);
        if ((state_nxt == SHOW1) && (state != SHOW1))
          hold <= HOLD_LOAD;
        else if ((state == SHOW1) && (hold != '0))
          hold <= hold - HW'(1);
      end
    end
  end

  always_comb begin
    code_sel = snap[3:0];
    case (idx)
      2'd0: code_sel = snap[3:0];
      2'd1: code_sel = snap[7:4];
      2'd2: code_sel = snap[11:8];
      2'd3: code_sel = snap[15:12];
      default: code_sel = snap[3:0];
    endcase
  end

  assign bus.an         = an_q;
  assign bus.code       = code_sel;
  assign bus.frame_done = frame_end;
  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;

endmodule
